ascon_perm_ctrl: RTL and testbench

Sequencer for the ASCON permutation datapath: constant addition, substitution layer and linear diffusion, closed around the 320-bit state register. On a start request it runs either the p^a permutation (12 rounds) or the p^b permutation (6 rounds). For each round it drives the 4-bit round index into the constant-addition stage. It also controls the state-register enable and the input/feedback multiplexer select, and it signals completion with a one-cycle done pulse. It is the only block that sequences rounds, and it sits between the mode FSM and the permutation datapath.

---
 rtl/ascon_perm_ctrl.sv | 100 ++++++++++
 tb/tb_ascon_perm_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the ASCON permutation datapath: runs p^a or p^b
// and drives the round index, state-register enable and input select.
module ascon_perm_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       hold_i,
  output logic [3:0] round_o,
  output logic       sel_init_o,
  output logic       en_state_o,
  output logic       busy_o,
  output logic       last_round_o,
  output logic       done_o
);

  // state | meaning
  // IDLE  | waiting for start_i; counter holds last value
  // ROUND | one round per unstalled cycle, index = counter
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
    $error("ROUNDS_A must be in 1..12");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
    $error("ROUNDS_B must be in 1..12");
  end

  // Rounds always end at index 11, so shorter permutations start later.
  localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST_IDX = 4'd11;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       first, first_nxt;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      first <= first_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    first_nxt = first;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = ROUND;
          cnt_nxt   = mode_i ? START_B : START_A;
          first_nxt = 1'b1;
        end
      end
      ROUND: begin
        if (!hold_i) begin
          first_nxt = 1'b0;
          if (cnt == LAST_IDX) state_nxt = DONE;
          else                 cnt_nxt   = cnt + 4'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only hold_i reaches the outputs combinationally, and only as a gate.
  always_comb begin
    round_o      = cnt;
    sel_init_o   = 1'b0;
    en_state_o   = 1'b0;
    busy_o       = 1'b0;
    last_round_o = 1'b0;
    done_o       = 1'b0;
    case (state)
      ROUND: begin
        busy_o = 1'b1;
        if (!hold_i) begin
          en_state_o   = 1'b1;
          sel_init_o   = first;
          last_round_o = (cnt == LAST_IDX);
        end
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: stimulus pushes expected per-cycle
// output records, a negedge monitor pops them whenever busy_o/done_o is up.
module tb_ascon_perm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] round_o;
  logic       sel_init_o, en_state_o, busy_o, last_round_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_seen = 0;
  int done_cyc  = 0;
  logic mon_en = 1'b0;

  // record = {round[3:0], sel_init, en_state, busy, last_round, done}
  logic [8:0] sb[$];

  ascon_perm_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .mode_i(mode),
    .hold_i(hold), .round_o(round_o), .sel_init_o(sel_init_o),
    .en_state_o(en_state_o), .busy_o(busy_o), .last_round_o(last_round_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] rec(input int r, input bit s, input bit e,
                                     input bit b, input bit l, input bit d);
    return {4'(r), s, e, b, l, d};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_o || done_o) begin
        if (done_o) begin
          done_seen++;
          done_cyc = cyc;
        end
        if (sb.size() == 0) begin
          check("unexpected_output", int'({round_o, sel_init_o, en_state_o,
                busy_o, last_round_o, done_o}), 0);
        end else begin
          logic [8:0] exp_r;
          exp_r = sb.pop_front();
          check("round_record", int'({round_o, sel_init_o, en_state_o, busy_o,
                last_round_o, done_o}), int'(exp_r));
        end
      end else begin
        check("idle_ctrl_zero", int'({sel_init_o, en_state_o, last_round_o}), 0);
      end
    end
  end

  // Expected records for one run starting at index 'first', stalled on the
  // cycles flagged in hmask (bit i = i-th cycle after the start edge).
  task automatic push_run(input int first, input logic [15:0] hmask);
    int  r = first;
    bit  f = 1'b1;
    int  i = 0;
    while (r <= 11) begin
      if (hmask[i]) sb.push_back(rec(r, 0, 0, 1, 0, 0));
      else begin
        sb.push_back(rec(r, f, 1, 1, r == 11, 0));
        f = 1'b0;
        r++;
      end
      i++;
    end
    sb.push_back(rec(11, 0, 0, 0, 0, 1));
  endtask

  task automatic drive_run(input logic m, input logic [15:0] hmask,
                           input int ncyc, input int exp_lat, input string name);
    int k0, d0;
    d0 = done_seen;
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    k0 = cyc;
    for (int i = 0; i < ncyc; i++) begin
      hold = hmask[i];
      @(posedge clk); #1;
    end
    hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_count"}, done_seen - d0, 1);
    check({name, "_done_latency"}, done_cyc - k0, exp_lat);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic check_all_zero(input string name, input int exp_round);
    @(negedge clk);
    check({name, "_round"}, int'(round_o), exp_round);
    check({name, "_ctrl"}, int'({sel_init_o, en_state_o, busy_o,
          last_round_o, done_o}), 0);
  endtask

  initial begin
    int d0, k0;
    // Reset then idle, with hold high for a while (must have no effect).
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; mon_en = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 10; i++) check_all_zero("idle", 0);
    hold = 1'b0;

    // Start together with reset: reset wins.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_all_zero("rst_start", 0);
    check_all_zero("rst_start2", 0);

    // p^a: rounds 0..11, done 12 cycles after the start edge's cycle.
    @(posedge clk); #1;
    push_run(0, 16'h0000);
    drive_run(1'b0, 16'h0000, 13, 12, "pa");

    // p^b: rounds 6..11.
    push_run(6, 16'h0000);
    drive_run(1'b1, 16'h0000, 7, 6, "pb");

    // p^b stalled on the first and third round cycles.
    push_run(6, 16'h0005);
    drive_run(1'b1, 16'h0005, 9, 8, "pb_stall");

    // Start held high through a p^a run and its DONE cycle; mode flips to 1
    // mid-run so the second, accepted start runs p^b.
    d0 = done_seen;
    push_run(0, 16'h0000);
    push_run(6, 16'h0000);
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    k0 = cyc;
    mode = 1'b1;
    repeat (14) @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("held_start_done_count", done_seen - d0, 2);
    check("held_start_done_latency", done_cyc - k0, 20);
    check("held_start_sb_empty", sb.size(), 0);

    // Reset while round 4 of p^a is presented: no done pulse.
    d0 = done_seen;
    for (int r = 0; r <= 4; r++) sb.push_back(rec(r, r == 0, 1, 1, 0, 0));
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midrst", 0);
    check_all_zero("midrst2", 0);
    check("midrst_no_done", done_seen - d0, 0);
    check("midrst_sb_empty", sb.size(), 0);

    // Fresh start after the aborted run completes normally.
    @(posedge clk); #1;
    push_run(0, 16'h0000);
    drive_run(1'b0, 16'h0000, 13, 12, "pa_after_rst");
    check_all_zero("final_idle", 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
